// File: rtl/uart_digit_parser.sv
// Parses "#<tens><units>\r" frames from a UART byte stream into a 6-bit display ID.
// Optional inter-byte timeout is enabled by defining PARSER_TIMEOUT_EN.
module uart_digit_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_busy,
   output logic [5:0] id,
   output logic       id_valid,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, TENS, UNITS, TERM} state_t;

   state_t     r_state;
   logic       r_busy_q;
   logic [2:0] r_tens;
   logic [3:0] r_units;
   logic [5:0] r_id;
   logic       r_id_valid;
   logic       r_frame_err;

   logic       w_strobe;
   logic       w_is_hash;
   logic       w_is_cr;
   logic       w_tens_ok;
   logic       w_units_ok;
   logic [6:0] w_value;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   assign w_strobe   = r_busy_q & ~rx_busy;
   assign w_is_hash  = (rx_data == 8'h23);
   assign w_is_cr    = (rx_data == 8'h0D);
   assign w_tens_ok  = (rx_data >= 8'h30) && (rx_data <= 8'h36);
   assign w_units_ok = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   // tens*10 as tens*8 + tens*2; max 69 fits in 7 bits
   assign w_value    = {1'b0, r_tens, 3'b000} + {3'b000, r_tens, 1'b0} + {3'b000, r_units};

`ifdef PARSER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] r_timer;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_busy_q    <= 1'b0;
         r_tens      <= 3'd0;
         r_units     <= 4'd0;
         r_id        <= 6'd0;
         r_id_valid  <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
         r_timer     <= '0;
`endif
      end else begin
         r_busy_q    <= rx_busy;
         r_id_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_strobe) begin
            case (r_state)
               IDLE: begin
                  if (w_is_hash) r_state <= TENS;
               end
               TENS: begin
                  if (w_is_hash) begin
                     r_frame_err <= 1'b1;
                  end else if (w_tens_ok) begin
                     r_tens  <= rx_data[2:0];
                     r_state <= UNITS;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
               UNITS: begin
                  if (w_is_hash) begin
                     r_frame_err <= 1'b1;
                     r_state     <= TENS;
                  end else if (w_units_ok) begin
                     r_units <= rx_data[3:0];
                     r_state <= TERM;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
               TERM: begin
                  if (w_is_hash) begin
                     r_frame_err <= 1'b1;
                     r_state     <= TENS;
                  end else if (w_is_cr && (w_value <= 7'd63)) begin
                     r_id       <= w_value[5:0];
                     r_id_valid <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
`ifdef PARSER_TIMEOUT_EN
         // a strobe in the same cycle wins over the timeout
         else if ((r_state != IDLE) && (r_timer == LAST_COUNT)) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
         end

         if (w_strobe || (r_state == IDLE) || (r_timer == LAST_COUNT))
            r_timer <= '0;
         else
            r_timer <= r_timer + 1'b1;
`endif
      end
   end

   assign id        = r_id;
   assign id_valid  = r_id_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_digit_parser.sv
// Directed bench for uart_digit_parser: a scoreboard queue holds expected id/error
// events, popped by a monitor whenever the parser pulses id_valid or frame_err.
module tb_uart_digit_parser;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_busy;
   logic [5:0] id;
   logic       id_valid;
   logic       frame_err;
   logic       busy;

   typedef logic [6:0] ev_t;
   localparam ev_t EV_ERR = 7'h40;

   ev_t exp_q[$];
   ev_t ev_obs;
   int  n_checks = 0;
   int  n_pass   = 0;

   uart_digit_parser #(.TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_busy   (rx_busy),
      .id        (id),
      .id_valid  (id_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Monitor: every output pulse must match the next scoreboard entry
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (id_valid && frame_err) begin
            check("pulse_exclusive", {id_valid, frame_err}, 2'b00);
         end else if (id_valid || frame_err) begin
            ev_obs = frame_err ? EV_ERR : {1'b0, id};
            if (exp_q.size() == 0) check("unexpected_pulse", ev_obs, 7'h7F);
            else                   check("sb_event", ev_obs, exp_q.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_busy = 1'b1;
      @(negedge clk);
      rx_busy = 1'b0;
      @(negedge clk);
      $display("byte 0x%02h -> id=%0d id_valid=%0b frame_err=%0b busy=%0b",
               b, id, id_valid, frame_err, busy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      reset   = 1'b1;
      rx_data = 8'h00;
      rx_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_id", id, 6'd0);
      check("rst_pulses", {id_valid, frame_err}, 2'b00);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_busy", busy, 1'b0);

      // "#42\r" -> id 42
      send_byte(8'h23);
      check("t1_busy", busy, 1'b1);
      send_byte(8'h34);
      send_byte(8'h32);
      exp_q.push_back({1'b0, 6'd42});
      send_byte(8'h0D);
      check("t1_id_valid", id_valid, 1'b1);
      check("t1_id", id, 6'd42);
      check("t1_busy_done", busy, 1'b0);
      @(negedge clk);
      check("t1_pulse_len", id_valid, 1'b0);

      // "#65\r" -> out of range, id holds
      send_byte(8'h23);
      send_byte(8'h36);
      send_byte(8'h35);
      exp_q.push_back(EV_ERR);
      send_byte(8'h0D);
      check("t2_frame_err", frame_err, 1'b1);
      check("t2_id_valid", id_valid, 1'b0);
      check("t2_id_hold", id, 6'd42);

      // "#1#07\r" -> resync on second '#', then id 7
      send_byte(8'h23);
      send_byte(8'h31);
      exp_q.push_back(EV_ERR);
      send_byte(8'h23);
      check("t3_resync_err", frame_err, 1'b1);
      check("t3_resync_busy", busy, 1'b1);
      send_byte(8'h30);
      send_byte(8'h37);
      exp_q.push_back({1'b0, 6'd7});
      send_byte(8'h0D);
      check("t3_id", id, 6'd7);
      check("t3_id_valid", id_valid, 1'b1);

      // "A\r" ignored in IDLE, then "#00\r" -> id 0
      send_byte(8'h41);
      check("t4_idle_busy", busy, 1'b0);
      send_byte(8'h0D);
      check("t4_idle_err", frame_err, 1'b0);
      send_byte(8'h23);
      send_byte(8'h30);
      send_byte(8'h30);
      exp_q.push_back({1'b0, 6'd0});
      send_byte(8'h0D);
      check("t4_id", id, 6'd0);
      check("t4_id_valid", id_valid, 1'b1);

      // upper boundary "#63\r"
      send_byte(8'h23);
      send_byte(8'h36);
      send_byte(8'h33);
      exp_q.push_back({1'b0, 6'd63});
      send_byte(8'h0D);
      check("t5_id63", id, 6'd63);

      // invalid tens digit '7'
      send_byte(8'h23);
      exp_q.push_back(EV_ERR);
      send_byte(8'h37);
      check("t6_bad_tens", frame_err, 1'b1);
      check("t6_busy", busy, 1'b0);

      // invalid terminator
      send_byte(8'h23);
      send_byte(8'h31);
      send_byte(8'h32);
      exp_q.push_back(EV_ERR);
      send_byte(8'h41);
      check("t7_bad_term", frame_err, 1'b1);
      check("t7_id_hold", id, 6'd63);

      // reset mid-frame clears immediately, then stray bytes ignored
      send_byte(8'h23);
      send_byte(8'h35);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t8_async_busy", busy, 1'b0);
      check("t8_async_id", id, 6'd0);
      @(negedge clk);
      reset = 1'b0;
      send_byte(8'h39);
      check("t8_busy_39", busy, 1'b0);
      send_byte(8'h0D);
      check("t8_pulses", {id_valid, frame_err}, 2'b00);
      check("t8_busy_cr", busy, 1'b0);

`ifdef PARSER_TIMEOUT_EN
      // '#' then silence: frame_err 16 cycles after the strobe edge
      send_byte(8'h23);
      exp_q.push_back(EV_ERR);
      cyc = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (frame_err) begin
            cyc = k;
            break;
         end
      end
      check("t9_timeout_cycles", cyc, 16);
      check("t9_timeout_busy", busy, 1'b0);
      send_byte(8'h31);
      check("t9_after_busy", busy, 1'b0);
`else
      // without the timeout the parser waits in a frame indefinitely
      send_byte(8'h23);
      repeat (40) @(negedge clk);
      check("t9_wait_busy", busy, 1'b1);
      exp_q.push_back(EV_ERR);
      send_byte(8'h0D);
      check("t9_wait_err", frame_err, 1'b1);
`endif

      repeat (5) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_digit_parser.md
UART_DIGIT_PARSER -- requirements
Module: uart_digit_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, sets the inter-byte timeout in clk cycles (used only under PARSER_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from the upstream UART receiver; sampled only on a byte strobe.
REQ-005 rx_busy  input  1  receiver busy flag; a 1->0 transition marks rx_data as a new valid byte.
REQ-006 id  output  6  last accepted display ID (0..63), registered, feeds the 7-segment display stage.
REQ-007 id_valid  output  1  one-cycle pulse when id takes a newly accepted value.
REQ-008 frame_err  output  1  one-cycle pulse on a malformed, out-of-range or timed-out frame.
REQ-009 busy  output  1  high while the parser is inside a frame (state != IDLE).

Function
REQ-010 The block SHALL register rx_busy into busy_q and SHALL generate strobe = busy_q & ~rx_busy; rx_data is consumed only at a clock edge where strobe = 1.
REQ-011 Frame format SHALL be '#'(0x23), tens digit '0'-'6' (0x30-0x36), units digit '0'-'9' (0x30-0x39), CR (0x0D).
REQ-012 FSM states SHALL be IDLE, TENS, UNITS, TERM; busy = 1 in every state except IDLE.
REQ-013 IDLE: '#' -> TENS; any other byte SHALL be ignored silently (no frame_err).
REQ-014 TENS: valid tens digit -> store tens, go to UNITS; UNITS: valid units digit -> store units, go to TERM.
REQ-015 TERM: CR SHALL compute value = tens*10 + units with a 7-bit result (tens*10 built as shift-add), then go to IDLE.
REQ-016 If value <= 63, id SHALL load value[5:0] and id_valid SHALL pulse, both visible in the cycle after the CR strobe edge (latency 1 cycle).
REQ-017 If value > 63 (60..69 range, e.g. "#64\r"), id SHALL hold and frame_err SHALL pulse.
REQ-018 Any invalid byte in TENS, UNITS or TERM SHALL pulse frame_err and return to IDLE, except '#'.
REQ-019 '#' received in TENS, UNITS or TERM SHALL pulse frame_err, discard the partial frame and go to TENS (resynchronise).
REQ-020 id_valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per event.
REQ-021 Back-to-back strobes on consecutive cycles SHALL each be processed; no byte is dropped.
REQ-022 id SHALL hold its value indefinitely between accepted frames.

Reset
REQ-023 reset SHALL asynchronously force state = IDLE, busy_q = 0, tens = 0, units = 0, id = 0, id_valid = 0, frame_err = 0, busy = 0, and timeout counter = 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no frame_err pulse; the first strobe after deassertion is parsed from IDLE.
REQ-025 With busy_q reset to 0, rx_busy low at reset release SHALL NOT generate a strobe.

Configuration
REQ-026 Macro PARSER_TIMEOUT_EN, when defined, SHALL add a counter that clears on every strobe and in IDLE and increments each cycle in other states.
REQ-027 With PARSER_TIMEOUT_EN, reaching TIMEOUT_CYCLES-1 without a strobe SHALL pulse frame_err and return to IDLE; a strobe in the same cycle takes priority.
REQ-028 Without PARSER_TIMEOUT_EN, no counter SHALL be synthesised and the parser SHALL wait in any state indefinitely.

Verification
REQ-029 Bytes 0x23,0x34,0x32,0x0D -> id = 42 (0x2A), single id_valid pulse one cycle after the CR strobe, frame_err never high.
REQ-030 Bytes 0x23,0x36,0x35,0x0D -> frame_err pulse, id unchanged from its previous value, id_valid low.
REQ-031 Bytes 0x23,0x31,0x23,0x30,0x37,0x0D -> one frame_err pulse on the second '#', then id = 7 with id_valid pulse.
REQ-032 Bytes 0x41,0x0D,0x23,0x30,0x30,0x0D -> no frame_err for the first two bytes, id = 0 with id_valid pulse.
REQ-033 Assert reset after 0x23,0x35 -> busy = 0, id = 0 immediately without a clock; then 0x39,0x0D -> ignored in IDLE, no pulses.
REQ-034 PARSER_TIMEOUT_EN, TIMEOUT_CYCLES = 16: send 0x23, then idle 16 cycles -> frame_err pulse, busy = 0; next 0x31 ignored.
